mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/div_iter.sv | 53 +++++
 rtl/mdu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit. Also provides the
// project-wide width and func-code defines when no defines header has set them.
`ifndef W_FUNC
`define W_FUNC 4
`endif
`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef FUNC_ADD
`define FUNC_ADD 4'd0
`endif
`ifndef FUNC_MUL
`define FUNC_MUL 4'd1
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 4'd2
`endif

package mdu_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 6;

  // Magnitude of a 32-bit operand; unsigned operands pass through.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction
endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider on operand magnitudes; one quotient bit
// per step, with the quotient/remainder sign fixups applied at the outputs.
module div_iter
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        step,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q, quo_q, dvs_q;
  logic        neg_q_q, neg_r_q;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] rem_next;

  // Trial subtraction is 33 bits wide because the shifted partial remainder
  // can exceed 32 bits before the subtract brings it back below the divisor.
  always_comb begin
    trial    = {rem_q, quo_q[31]};
    ge       = (trial >= {1'b0, dvs_q});
    rem_next = ge ? (trial[31:0] - dvs_q) : trial[31:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (load) begin
      rem_q   <= '0;
      quo_q   <= mag(dividend, sign);
      dvs_q   <= mag(divisor, sign);
      neg_q_q <= sign & (dividend[31] ^ divisor[31]);
      neg_r_q <= sign & dividend[31];
    end else if (step) begin
      rem_q <= rem_next;
      quo_q <= {quo_q[30:0], ge};
    end
  end

  assign quotient  = neg_q_q ? (32'd0 - quo_q) : quo_q;
  assign remainder = neg_r_q ? (32'd0 - rem_q) : rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the EX stage: MUL/DIV/DONE FSM, product, HI/LO writes.
// Build option MDU_DIVZERO_FAST_EN: divide by zero skips the iterations and goes to DONE.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [`W_FUNC-1:0]  func,
  input  logic                sign,
  input  logic [`W_DATA-1:0]  source_a,
  input  logic [`W_DATA-1:0]  source_b,
  input  logic                flush,
  output logic                stall,
  output logic                busy,
  output logic                hi_write,
  output logic                lo_write,
  output logic [`W_DATA-1:0]  hi_write_data,
  output logic [`W_DATA-1:0]  lo_write_data,
  output mdu_state_t          dbg_state
);

  // Handshake: a request is accepted only in IDLE when start=1 with a MUL/DIV
  // func and no flush; stall is raised in that same cycle and held through
  // MUL/DIV, drops in DONE (the one-cycle HI/LO write), and flush always wins.

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      a_q, b_q;
  logic             sign_q, is_div_q;
  logic             accept, wr, div_load, div_step, is_mul_req, is_div_req;
  logic [63:0]      product;
  logic [31:0]      quotient, remainder;
  logic [31:0]      hi_d, lo_d;
  logic             stall_raw;
`ifdef MDU_DIVZERO_FAST_EN
  logic             dz_q;
`endif

  assign is_mul_req = start && (func == `FUNC_MUL);
  assign is_div_req = start && (func == `FUNC_DIV);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    stall_raw = 1'b0;
    accept    = 1'b0;
    wr        = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((is_mul_req || is_div_req) && !flush) begin
          accept    = 1'b1;
          stall_raw = 1'b1;
          if (is_mul_req) begin
            state_d = ST_MUL;
            count_d = CNT_W'(MUL_CYCLES);
          end else begin
            div_load = 1'b1;
            state_d  = ST_DIV;
            count_d  = CNT_W'(DIV_ITERS);
`ifdef MDU_DIVZERO_FAST_EN
            if (source_b == '0) begin
              state_d = ST_DONE;
              count_d = '0;
            end
`endif
          end
        end
      end
      ST_MUL: begin
        stall_raw = 1'b1;
        count_d   = count_q - 1'b1;
        if (count_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DIV: begin
        stall_raw = 1'b1;
        div_step  = 1'b1;
        count_d   = count_q - 1'b1;
        if (count_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        wr      = 1'b1;
        count_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      stall_raw = 1'b0;
      wr        = 1'b0;
      div_step  = 1'b0;
      count_d   = '0;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        a_q      <= source_a;
        b_q      <= source_b;
        sign_q   <= sign;
        is_div_q <= is_div_req;
      end
    end
  end

`ifdef MDU_DIVZERO_FAST_EN
  always_ff @(posedge clk) begin
    if (!resetn)    dz_q <= 1'b0;
    else if (accept) dz_q <= is_div_req && (source_b == '0);
  end
`endif

  // Sign-extending both operands to 64 bits makes the low 64 bits of the
  // unsigned product equal to the signed product.
  always_comb begin
    product = {{32{sign_q & a_q[31]}}, a_q} * {{32{sign_q & b_q[31]}}, b_q};
  end

  div_iter u_div_iter (
    .clk       (clk),
    .resetn    (resetn),
    .load      (div_load),
    .step      (div_step),
    .sign      (sign),
    .dividend  (source_a),
    .divisor   (source_b),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_comb begin
    hi_d = product[63:32];
    lo_d = product[31:0];
    if (is_div_q) begin
      hi_d = remainder;
      lo_d = quotient;
    end
`ifdef MDU_DIVZERO_FAST_EN
    if (dz_q) begin
      hi_d = a_q;
      lo_d = 32'hFFFF_FFFF;
    end
`endif
  end

  assign stall         = stall_raw & resetn;
  assign busy          = (state_q != ST_IDLE);
  assign hi_write      = wr & resetn;
  assign lo_write      = wr & resetn;
  assign hi_write_data = hi_write ? hi_d : '0;
  assign lo_write_data = lo_write ? lo_d : '0;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized and directed bench for mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MUL_CYC = 2;

  logic               clk = 1'b0;
  logic               resetn, start, sign, flush;
  logic [`W_FUNC-1:0] func;
  logic [31:0]        source_a, source_b;
  logic               stall, busy, hi_write, lo_write;
  logic [31:0]        hi_write_data, lo_write_data;
  mdu_state_t         dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  mdu_ctrl #(.MUL_CYCLES(MUL_CYC)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .func          (func),
    .sign          (sign),
    .source_a      (source_a),
    .source_b      (source_b),
    .flush         (flush),
    .stall         (stall),
    .busy          (busy),
    .hi_write      (hi_write),
    .lo_write      (lo_write),
    .hi_write_data (hi_write_data),
    .lo_write_data (lo_write_data),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} from the arithmetic definition of each operation.
  function automatic logic [63:0] ref_result(input logic is_div, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint ua, ub, q, r;
    logic [63:0] pv;
    if (!is_div) begin
      sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      p  = sa * sb;
      pv = p;
      return pv;
    end
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    ua = (sa < 0) ? -sa : sa;
    ub = (sb < 0) ? -sb : sb;
    if (ub == 0) begin
      q = 64'h0000_0000_FFFF_FFFF;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if ((sa < 0) != (sb < 0)) q = -q;
    if (sa < 0) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_stalls(input logic is_div, input logic [31:0] b);
    if (!is_div) return 1 + MUL_CYC;
`ifdef MDU_DIVZERO_FAST_EN
    if (b == 32'd0) return 1;
`endif
    return 1 + 32;
  endfunction

  // Issues one request, holding start until the write cycle, then checks the result.
  task automatic run_op(input logic [`W_FUNC-1:0] f, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
    int          stalls;
    logic        got_wr, data_ok, is_div;
    logic [63:0] exp;
    @(negedge clk);
    start = 1'b1; func = f; sign = s; source_a = a; source_b = b;
    #1;
    if (f != `FUNC_MUL && f != `FUNC_DIV) begin
      check("badfunc_stall", stall, 0);
      check("badfunc_wr", {hi_write, lo_write}, 0);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("badfunc_busy", busy, 0);
      return;
    end
    is_div  = (f == `FUNC_DIV);
    exp     = ref_result(is_div, s, a, b);
    stalls  = 0;
    got_wr  = 1'b0;
    data_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (hi_write || lo_write) begin
        got_wr = 1'b1;
        break;
      end
      if (stall) stalls++;
      if (hi_write_data != 0 || lo_write_data != 0) data_ok = 1'b0;
      @(negedge clk);
      #1;
    end
    check("op_timeout", got_wr, 1);
    check("stall_cycles", stalls, ref_stalls(is_div, b));
    check("wr_pair", {hi_write, lo_write}, 2'b11);
    check("hi", hi_write_data, exp[63:32]);
    check("lo", lo_write_data, exp[31:0]);
    check("done_stall", stall, 0);
    check("idle_data_zero", data_ok, 1);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("post_busy", busy, 0);
    check("post_wr", {hi_write, lo_write, stall}, 0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        saw_wr;
    logic [31:0] ra, rb;
    logic [`W_FUNC-1:0] rf;
    int          sel;
    resetn = 1'b0; start = 1'b0; sign = 1'b0; flush = 1'b0;
    func = `FUNC_ADD; source_a = '0; source_b = '0;
    repeat (3) @(negedge clk);
    start = 1'b1; func = `FUNC_MUL; source_a = 32'd7; source_b = 32'd9;
    #1;
    check("rst_stall", stall, 0);
    check("rst_busy", busy, 0);
    check("rst_wr", {hi_write, lo_write}, 0);
    check("rst_data", {hi_write_data, lo_write_data}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    run_op(`FUNC_MUL, 1'b0, 32'hFFFF_FFFF, 32'd2);
    run_op(`FUNC_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(`FUNC_DIV, 1'b0, 32'd100, 32'd7);
    run_op(`FUNC_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(`FUNC_ADD, 1'b0, 32'd1, 32'd2);
    run_op(`FUNC_DIV, 1'b0, 32'd5, 32'd0);
    run_op(`FUNC_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0);

    // Flush in the tenth DIV cycle.
    @(negedge clk);
    start = 1'b1; func = `FUNC_DIV; sign = 1'b0; source_a = 32'd100; source_b = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    #1;
    check("flush_stall", stall, 0);
    check("flush_wr", {hi_write, lo_write}, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle", busy, 0);
    run_op(`FUNC_MUL, 1'b0, 32'd3, 32'd4);

    // Reset during MUL cycle 1.
    @(negedge clk);
    start = 1'b1; func = `FUNC_MUL; sign = 1'b0; source_a = 32'd3; source_b = 32'd5;
    @(negedge clk);
    resetn = 1'b0; start = 1'b0;
    #1;
    check("midrst_stall", stall, 0);
    @(negedge clk);
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_outs", {stall, hi_write, lo_write, hi_write_data, lo_write_data}, 0);
    resetn = 1'b1;
    saw_wr = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (hi_write || lo_write || busy) saw_wr = 1'b1;
    end
    check("midrst_no_wr", saw_wr, 0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      rf  = (sel < 4) ? `FUNC_MUL : (sel < 8) ? `FUNC_DIV : (sel == 8) ? `FUNC_ADD : 4'd3;
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rf, 1'($urandom_range(0, 1)), ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
